plot_sweep_controller: RTL and testbench
========================================

# plot_sweep_controller

Sequences the stack-machine expression evaluator across one screen sweep. For each pixel column it issues an x value in Q8.8, waits for the evaluator's y, maps y to a screen row, and hands a (column, row, visible) record to the plot rasteriser. It sits between the top-level control (start/abort) and the evaluator's start/done handshake, and it is the only block that drives the evaluator's x input.

## Interface
- INTEGER_PART_WIDTH, 8, integer bits of the fixed-point number
- FRACTIONAL_PART_WIDTH, 8, fractional bits
- NUMBER_WIDTH, INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH, width of x/y
- SCREEN_WIDTH, 640, number of columns swept
- SCREEN_HEIGHT, 480, number of rows
- Y_CENTER, 240, row index of y = 0
- PPU_LOG2, 2, log2 pixels per unit of y (≤ FRACTIONAL_PART_WIDTH)
- TIMEOUT_CYCLES, 4096, evaluator watchdog limit (only with the macro)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  cancel sweep; highest priority after rst
- x_min  in  NUMBER_WIDTH  signed Q x of column 0; latched at start
- x_step  in  NUMBER_WIDTH  signed Q x increment per column; latched at start
- eval_start  out  1  one-cycle evaluator start pulse
- eval_x  out  NUMBER_WIDTH  x for the evaluator; stable from eval_start until eval_done
- eval_done  in  1  evaluator result strobe
- eval_y  in  NUMBER_WIDTH  signed Q result; valid with eval_done
- pix_valid  out  1  pixel record valid
- pix_ready  in  1  rasteriser accepts the record
- pix_col  out  clog2(SCREEN_WIDTH)  column
- pix_row  out  clog2(SCREEN_HEIGHT)  row; 0 when not visible
- pix_visible  out  1  row lies within the screen
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at sweep completion
- timeout_err  out  1  sticky; only with the macro, otherwise tied to 0

## Operation
- States: IDLE, ISSUE, WAIT_EVAL, EMIT, FINISH.
- IDLE: on start, latch x_min and x_step, set col=0 and eval_x=x_min, then go to ISSUE. start in any other state is ignored.
- ISSUE: eval_start=1 for exactly one cycle, then go to WAIT_EVAL.
- WAIT_EVAL: on eval_done, capture the mapped row and visible flag, then go to EMIT. eval_done in any other state is ignored.
- EMIT: hold pix_valid with a stable record until pix_ready.
  - On handshake with col = SCREEN_WIDTH-1, go to FINISH.
  - On any other handshake, col+1, eval_x += x_step, go to ISSUE.
- FINISH: done=1 for one cycle, then go to IDLE.
- x arithmetic: two's-complement addition, wraps modulo 2^NUMBER_WIDTH, no saturation.
- Row mapping:
  - s = eval_y >>> (FRACTIONAL_PART_WIDTH − PPU_LOG2), arithmetic shift.
  - r = Y_CENTER − s, computed at NUMBER_WIDTH+2 bits signed.
  - visible = 0 ≤ r < SCREEN_HEIGHT.
- abort in a non-IDLE state: next state is IDLE. Pending eval_start and pix_valid drop, done does not pulse, and col resets to 0.
- rst mid-sweep: immediate return to IDLE with all outputs at their reset values. The evaluator must also be reset by the same rst.

## Timing
- Reset values: all outputs 0, state IDLE, col 0, latched x registers 0; timeout_err 0.
- start registered at edge N: state is ISSUE and eval_start=1 in cycle N+1.
- Per-column minimum: 3 cycles (ISSUE, WAIT_EVAL with eval_done in the same cycle, EMIT with pix_ready high).
- pix_valid rises the cycle after eval_done is sampled. It is never withdrawn without a handshake, except on abort or rst.
- done asserts exactly one cycle after the last pixel handshake.

## Configuration
- PLOT_SWEEP_TIMEOUT_EN defined:
  - A counter runs in WAIT_EVAL. After TIMEOUT_CYCLES cycles without eval_done, it emits the column with pix_visible=0 and sets timeout_err.
  - timeout_err clears on the next start or on rst.
- PLOT_SWEEP_TIMEOUT_EN undefined: no counter; WAIT_EVAL waits indefinitely; timeout_err is constant 0.

## Structure
- Package plot_pkg holds:
  - the state enum
  - the Q-format width constants
  - the default SCREEN_WIDTH/HEIGHT, Y_CENTER and PPU_LOG2
- Sub-module plot_row_mapper: combinational eval_y → (row, visible) per the rule above. It is instantiated once and reused by the rasteriser's testbench.

## Test plan
- Sweep with SCREEN_WIDTH=4, x_min=0xFF00 (−1.0), x_step=0x0080 (0.5), evaluator replies after 2 cycles, pix_ready=1 → eval_x sequence FF00, FF80, 0000, 0080; pix_col 0..3; a single done pulse after the 4th handshake.
- Row mapping with defaults:
  - eval_y=0x0A40 (10.25) → row 199, visible.
  - eval_y=0xF000 (−16.0) → row 304, visible.
  - eval_y=0x6400 (100.0) → visible=0, row 0.
- Backpressure: pix_ready held low for 5 cycles → pix_valid, pix_col and pix_row stable throughout; eval_start does not pulse until the handshake.
- Abort during WAIT_EVAL of column 2 → IDLE next cycle, busy=0, no done. A late eval_done is ignored. A new start restarts at col 0 with x_min.
- x wrap: x_min=0x7F00, x_step=0x0200 → second eval_x=0x8100.
- With PLOT_SWEEP_TIMEOUT_EN and TIMEOUT_CYCLES=16, evaluator never answers → after 16 WAIT_EVAL cycles, pix_visible=0, timeout_err=1, and the sweep continues to done.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared types and defaults for the plot sweep path.
// Build option: PLOT_SWEEP_TIMEOUT_EN enables the evaluator watchdog.
package plot_pkg;

    localparam int DEF_INT_W          = 8;
    localparam int DEF_FRAC_W         = 8;
    localparam int DEF_NUM_W          = DEF_INT_W + DEF_FRAC_W;
    localparam int DEF_SCREEN_WIDTH   = 640;
    localparam int DEF_SCREEN_HEIGHT  = 480;
    localparam int DEF_Y_CENTER       = 240;
    localparam int DEF_PPU_LOG2       = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_EVAL,
        EMIT,
        FINISH
    } state_t;

endpackage

// File: rtl/plot_row_mapper.sv
// Maps a signed Q-format y to a screen row; row 0 and visible=0 when off-screen.
// Build option: none (PLOT_SWEEP_TIMEOUT_EN only affects the controller).
module plot_row_mapper
    import plot_pkg::*;
#(
    parameter int NUMBER_WIDTH          = DEF_NUM_W,
    parameter int FRACTIONAL_PART_WIDTH = DEF_FRAC_W,
    parameter int SCREEN_HEIGHT         = DEF_SCREEN_HEIGHT,
    parameter int Y_CENTER              = DEF_Y_CENTER,
    parameter int PPU_LOG2              = DEF_PPU_LOG2,
    parameter int ROW_W                 = $clog2(SCREEN_HEIGHT)
) (
    input  logic [NUMBER_WIDTH-1:0] y,
    output logic [ROW_W-1:0]        row,
    output logic                    visible
);

    localparam int SHIFT = FRACTIONAL_PART_WIDTH - PPU_LOG2;
    localparam int RW    = NUMBER_WIDTH + 2;
    localparam logic signed [RW-1:0] YC = RW'(Y_CENTER);
    localparam logic signed [RW-1:0] HT = RW'(SCREEN_HEIGHT);

    logic signed [RW-1:0] y_ext;
    logic signed [RW-1:0] s;
    logic signed [RW-1:0] r;

    // Two guard bits keep Y_CENTER - s from overflowing for any y.
    assign y_ext   = {{2{y[NUMBER_WIDTH-1]}}, y};
    assign s       = y_ext >>> SHIFT;
    assign r       = YC - s;
    assign visible = !r[RW-1] && (r < HT);
    assign row     = visible ? r[ROW_W-1:0] : '0;

endmodule

// File: rtl/plot_sweep_controller.sv
// Drives the expression evaluator once per column and emits pixel records.
// Build option: PLOT_SWEEP_TIMEOUT_EN adds a WAIT_EVAL watchdog and timeout_err.
module plot_sweep_controller
    import plot_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = DEF_INT_W,
    parameter int FRACTIONAL_PART_WIDTH = DEF_FRAC_W,
    parameter int NUMBER_WIDTH          = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    parameter int SCREEN_WIDTH          = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT         = DEF_SCREEN_HEIGHT,
    parameter int Y_CENTER              = DEF_Y_CENTER,
    parameter int PPU_LOG2              = DEF_PPU_LOG2
`ifdef PLOT_SWEEP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES        = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUMBER_WIDTH-1:0]          x_min,
    input  logic [NUMBER_WIDTH-1:0]          x_step,
    output logic                             eval_start,
    output logic [NUMBER_WIDTH-1:0]          eval_x,
    input  logic                             eval_done,
    input  logic [NUMBER_WIDTH-1:0]          eval_y,
    output logic                             pix_valid,
    input  logic                             pix_ready,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  pix_col,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] pix_row,
    output logic                             pix_visible,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout_err
);

    localparam int COL_W = $clog2(SCREEN_WIDTH);
    localparam int ROW_W = $clog2(SCREEN_HEIGHT);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_WIDTH - 1);

    state_t                  state;
    logic [COL_W-1:0]        col;
    logic [NUMBER_WIDTH-1:0] x_step_q;
    logic [ROW_W-1:0]        row_m;
    logic                    vis_m;

    plot_row_mapper #(
        .NUMBER_WIDTH          (NUMBER_WIDTH),
        .FRACTIONAL_PART_WIDTH (FRACTIONAL_PART_WIDTH),
        .SCREEN_HEIGHT         (SCREEN_HEIGHT),
        .Y_CENTER              (Y_CENTER),
        .PPU_LOG2              (PPU_LOG2),
        .ROW_W                 (ROW_W)
    ) u_row_mapper (
        .y       (eval_y),
        .row     (row_m),
        .visible (vis_m)
    );

    assign busy    = (state != IDLE);
    assign pix_col = col;

`ifdef PLOT_SWEEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tcnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            col         <= '0;
            x_step_q    <= '0;
            eval_x      <= '0;
            eval_start  <= 1'b0;
            pix_valid   <= 1'b0;
            pix_row     <= '0;
            pix_visible <= 1'b0;
            done        <= 1'b0;
`ifdef PLOT_SWEEP_TIMEOUT_EN
            tcnt        <= '0;
            timeout_err <= 1'b0;
`endif
        end else if (abort && state != IDLE) begin
            state       <= IDLE;
            col         <= '0;
            eval_start  <= 1'b0;
            pix_valid   <= 1'b0;
            pix_row     <= '0;
            pix_visible <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_step_q   <= x_step;
                        eval_x     <= x_min;
                        col        <= '0;
                        eval_start <= 1'b1;
                        state      <= ISSUE;
`ifdef PLOT_SWEEP_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    eval_start <= 1'b0;
                    state      <= WAIT_EVAL;
`ifdef PLOT_SWEEP_TIMEOUT_EN
                    tcnt       <= '0;
`endif
                end
                WAIT_EVAL: begin
                    if (eval_done) begin
                        pix_row     <= row_m;
                        pix_visible <= vis_m;
                        pix_valid   <= 1'b1;
                        state       <= EMIT;
                    end
`ifdef PLOT_SWEEP_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        pix_row     <= '0;
                        pix_visible <= 1'b0;
                        pix_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                EMIT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (col == LAST_COL) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            col        <= col + 1'b1;
                            eval_x     <= eval_x + x_step_q;
                            eval_start <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plot_sweep_controller.sv
// Directed-plus-random bench for plot_sweep_controller on a 4-column screen.
// Expected x and row values come from plain arithmetic on the sweep rules.
module tb_plot_sweep_controller;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] x_min = '0;
    logic [15:0] x_step = '0;
    logic        eval_start;
    logic [15:0] eval_x;
    logic        eval_done = 1'b0;
    logic [15:0] eval_y = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [1:0]  pix_col;
    logic [8:0]  pix_row;
    logic        pix_visible;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int passed = 0;
    int total  = 0;
    logic [15:0] m_min;
    logic [15:0] m_step;

    plot_sweep_controller #(.SCREEN_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .x_min       (x_min),
        .x_step      (x_step),
        .eval_start  (eval_start),
        .eval_x      (eval_x),
        .eval_done   (eval_done),
        .eval_y      (eval_y),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_col     (pix_col),
        .pix_row     (pix_row),
        .pix_visible (pix_visible),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // x of column i: x_min + i*x_step, wrapped to 16 bits.
    function automatic logic [15:0] model_x(input int i);
        int v;
        v = int'($signed(m_min)) + i * int'($signed(m_step));
        return v[15:0];
    endfunction

    // Four pixels per unit of y, y=0 on row 240, 480 rows.
    function automatic void model_row(input logic [15:0] y, output int row, output bit vis);
        int s;
        int r;
        s   = int'($signed(y)) >>> 6;
        r   = 240 - s;
        vis = (r >= 0) && (r < 480);
        row = vis ? r : 0;
    endfunction

    task automatic start_sweep(input logic [15:0] xmin, input logic [15:0] xstep);
        m_min  = xmin;
        m_step = xstep;
        x_min  = xmin;
        x_step = xstep;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        x_min  = 16'($urandom);
        x_step = 16'($urandom);
        chk("start_busy", busy, 1);
    endtask

    // Entered on the negedge of column i's ISSUE cycle.
    task automatic do_column(input int i, input logic [15:0] y, input int d,
                             input int k, input bit last, input bit poke);
        int row;
        bit vis;
        chk("issue_start", eval_start, 1);
        chk("issue_x", eval_x, model_x(i));
        chk("issue_col", pix_col, i);
        @(negedge clk);
        chk("wait_start_low", eval_start, 0);
        for (int j = 0; j < d; j++) begin
            start = poke;
            chk("wait_valid_low", pix_valid, 0);
            @(negedge clk);
        end
        start     = 1'b0;
        eval_done = 1'b1;
        eval_y    = y;
        @(negedge clk);
        eval_done = 1'b0;
        eval_y    = 16'($urandom);
        model_row(y, row, vis);
        chk("emit_valid", pix_valid, 1);
        chk("emit_col", pix_col, i);
        chk("emit_row", pix_row, row);
        chk("emit_vis", pix_visible, vis);
        chk("emit_done_low", done, 0);
        for (int j = 0; j < k; j++) begin
            @(negedge clk);
            chk("bp_valid", pix_valid, 1);
            chk("bp_col", pix_col, i);
            chk("bp_row", pix_row, row);
            chk("bp_vis", pix_visible, vis);
            chk("bp_no_start", eval_start, 0);
        end
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
        chk("post_valid_low", pix_valid, 0);
        if (last) begin
            chk("done_pulse", done, 1);
            chk("finish_start_low", eval_start, 0);
            @(negedge clk);
            chk("done_single", done, 0);
            chk("idle_busy", busy, 0);
        end else begin
            chk("next_done_low", done, 0);
        end
    endtask

    task automatic random_sweep(input logic [15:0] xmin, input logic [15:0] xstep);
        start_sweep(xmin, xstep);
        for (int i = 0; i < W; i++) begin
            do_column(i, 16'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 2), i == W - 1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_eval_start", eval_start, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_eval_x", eval_x, 0);
        chk("reset_valid", pix_valid, 0);
        chk("reset_col", pix_col, 0);
        chk("reset_row", pix_row, 0);
        chk("reset_done", done, 0);
        chk("reset_terr", timeout_err, 0);

        // Directed sweep: -1.0 step 0.5, evaluator latency 2, known rows.
        start_sweep(16'hFF00, 16'h0080);
        do_column(0, 16'h0A40, 2, 0, 1'b0, 1'b0);
        do_column(1, 16'hF000, 2, 0, 1'b0, 1'b0);
        do_column(2, 16'h6400, 2, 0, 1'b0, 1'b0);
        do_column(3, 16'h0000, 2, 0, 1'b1, 1'b0);

        // Backpressure of 5 cycles on every column.
        start_sweep(16'h0100, 16'hFFC0);
        for (int i = 0; i < W; i++)
            do_column(i, 16'($urandom), 1, 5, i == W - 1, 1'b1);

        // x wrap through the positive limit.
        start_sweep(16'h7F00, 16'h0200);
        do_column(0, 16'($urandom), 0, 0, 1'b0, 1'b0);
        chk("wrap_x", eval_x, 16'h8100);
        for (int i = 1; i < W; i++)
            do_column(i, 16'($urandom), 0, 1, i == W - 1, 1'b0);

        for (int n = 0; n < 4; n++)
            random_sweep(16'($urandom), 16'($urandom));

        // Abort while column 2 waits for the evaluator.
        start_sweep(16'h1234, 16'h0040);
        do_column(0, 16'($urandom), 1, 0, 1'b0, 1'b0);
        do_column(1, 16'($urandom), 1, 0, 1'b0, 1'b0);
        chk("abort_issue_x", eval_x, model_x(2));
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", pix_valid, 0);
        chk("abort_start", eval_start, 0);
        chk("abort_done", done, 0);
        chk("abort_col", pix_col, 0);
        eval_done = 1'b1;
        eval_y    = 16'h0000;
        @(negedge clk);
        eval_done = 1'b0;
        chk("late_done_valid", pix_valid, 0);
        chk("late_done_busy", busy, 0);
        @(negedge clk);
        chk("late_done_nodone", done, 0);
        chk("late_done_nostart", eval_start, 0);

        random_sweep(16'hC000, 16'h0100);
        chk("final_terr", timeout_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
